// File: rtl/cosim_endpoint_xfer.sv
// Cosim endpoint adapter: registers one endpoint, then moves whole messages between the
// host endpoint functions and valid/ready streams. Also holds the host-side endpoint server.
package cosim_ep_pkg;
  localparam int MAX_EPS   = 8;
  localparam int MAX_BYTES = 16;
  localparam int QDEPTH    = 16;

  typedef logic [8*MAX_BYTES-1:0] msg_t;
  typedef logic [2:0]             ep_idx_t;
  typedef logic [3:0]             qptr_t;

  bit          ep_reg_q      [MAX_EPS];
  logic [63:0] ep_type       [MAX_EPS];
  int          ep_recv_bytes [MAX_EPS];
  int          register_calls[MAX_EPS];
  int          tryget_calls  [MAX_EPS];
  bit          put_fail;

  msg_t  h2r_data [MAX_EPS][QDEPTH];
  int    h2r_len  [MAX_EPS][QDEPTH];
  qptr_t h2r_rd   [MAX_EPS];
  qptr_t h2r_wr   [MAX_EPS];
  int    h2r_cnt  [MAX_EPS];
  msg_t  r2h_data [MAX_EPS][QDEPTH];
  int    r2h_len  [MAX_EPS][QDEPTH];
  qptr_t r2h_rd   [MAX_EPS];
  qptr_t r2h_wr   [MAX_EPS];
  int    r2h_cnt  [MAX_EPS];

  function automatic bit ep_ok(input int ep_id);
    return (ep_id >= 0) && (ep_id < MAX_EPS);
  endfunction

  // A second registration of the same id is rejected as a duplicate.
  function automatic int cosim_ep_register(input int ep_id, input logic [63:0] type_id,
                                           input int recv_bytes);
    ep_idx_t ix;
    if (!ep_ok(ep_id)) return -1;
    ix = ep_idx_t'(ep_id);
    register_calls[ix] = register_calls[ix] + 1;
    if (ep_reg_q[ix]) return -1;
    ep_reg_q[ix]      = 1'b1;
    ep_type[ix]       = type_id;
    ep_recv_bytes[ix] = recv_bytes;
    return 0;
  endfunction

  function automatic int cosim_ep_tryget(input int ep_id, output msg_t data, inout int size_bytes);
    ep_idx_t ix;
    qptr_t   rp;
    data = '0;
    if (!ep_ok(ep_id)) begin
      size_bytes = 0;
      return -1;
    end
    ix = ep_idx_t'(ep_id);
    tryget_calls[ix] = tryget_calls[ix] + 1;
    if (!ep_reg_q[ix]) begin
      size_bytes = 0;
      return -1;
    end
    if (h2r_cnt[ix] == 0) begin
      size_bytes = 0;
      return 0;
    end
    rp          = h2r_rd[ix];
    h2r_rd[ix]  = rp + qptr_t'(1);
    h2r_cnt[ix] = h2r_cnt[ix] - 1;
    if (h2r_len[ix][rp] > size_bytes) begin
      size_bytes = h2r_len[ix][rp];
      return 1;
    end
    size_bytes = h2r_len[ix][rp];
    data       = h2r_data[ix][rp];
    return 0;
  endfunction

  function automatic int cosim_ep_tryput(input int ep_id, input msg_t data, input int data_limit);
    ep_idx_t ix;
    if (!ep_ok(ep_id)) return -1;
    ix = ep_idx_t'(ep_id);
    if (!ep_reg_q[ix] || put_fail || r2h_cnt[ix] >= QDEPTH) return -1;
    r2h_data[ix][r2h_wr[ix]] = data;
    r2h_len[ix][r2h_wr[ix]]  = data_limit;
    r2h_wr[ix]  = r2h_wr[ix] + qptr_t'(1);
    r2h_cnt[ix] = r2h_cnt[ix] + 1;
    return 0;
  endfunction

  function automatic void host_push(input int ep_id, input msg_t data, input int len);
    ep_idx_t ix;
    if (!ep_ok(ep_id)) return;
    ix = ep_idx_t'(ep_id);
    if (h2r_cnt[ix] >= QDEPTH) return;
    h2r_data[ix][h2r_wr[ix]] = data;
    h2r_len[ix][h2r_wr[ix]]  = len;
    h2r_wr[ix]  = h2r_wr[ix] + qptr_t'(1);
    h2r_cnt[ix] = h2r_cnt[ix] + 1;
  endfunction

  function automatic bit host_pop(input int ep_id, output msg_t data, output int len);
    ep_idx_t ix;
    data = '0;
    len  = 0;
    if (!ep_ok(ep_id)) return 1'b0;
    ix = ep_idx_t'(ep_id);
    if (r2h_cnt[ix] == 0) return 1'b0;
    data = r2h_data[ix][r2h_rd[ix]];
    len  = r2h_len[ix][r2h_rd[ix]];
    r2h_rd[ix]  = r2h_rd[ix] + qptr_t'(1);
    r2h_cnt[ix] = r2h_cnt[ix] - 1;
    return 1'b1;
  endfunction

  function automatic int host_pending(input int ep_id);
    if (!ep_ok(ep_id)) return 0;
    return h2r_cnt[ep_idx_t'(ep_id)];
  endfunction

  function automatic logic [63:0] host_type_id(input int ep_id);
    if (!ep_ok(ep_id)) return '0;
    return ep_type[ep_idx_t'(ep_id)];
  endfunction

  function automatic int host_recv_bytes(input int ep_id);
    if (!ep_ok(ep_id)) return 0;
    return ep_recv_bytes[ep_idx_t'(ep_id)];
  endfunction
endpackage

module cosim_endpoint_xfer #(
  parameter int          ENDPOINT_ID   = 0,
  parameter logic [63:0] ESI_TYPE_ID   = 64'd0,
  parameter int          RECV_BITS     = 32,
  parameter int          SEND_BITS     = 32,
  parameter int          POLL_INTERVAL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 DataOutValid,
  input  logic                 DataOutReady,
  output logic [RECV_BITS-1:0] DataOut,
  input  logic                 DataInValid,
  output logic                 DataInReady,
  input  logic [SEND_BITS-1:0] DataIn,
  output logic                 Registered,
  output logic                 Error,
  output logic [15:0]          DropCount
);
  import cosim_ep_pkg::*;

  localparam int RECV_BYTES = (RECV_BITS + 7) / 8;
  localparam int SEND_BYTES = (SEND_BITS + 7) / 8;
  localparam int PW         = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_INTERVAL - 1);

  typedef enum logic [1:0] {ST_REG, ST_ACTIVE, ST_ERR} state_t;

  typedef struct packed {
    state_t               st;
    logic                 reg_flag;
    logic                 out_valid;
    logic [RECV_BITS-1:0] out_data;
    logic                 err;
    logic [15:0]          drop;
    logic [PW-1:0]        poll;
  } regs_t;

  // reg_flag lives for the whole simulation; reset never clears it.
  regs_t         regs_q = '0;
  logic          active;
  logic          accept;
  logic          get_en;
  logic          put_en;
  logic [PW-1:0] poll_d;

  function automatic regs_t reset_regs(input logic flag);
    regs_t r;
    r          = '0;
    r.reg_flag = flag;
    r.st       = flag ? ST_ACTIVE : ST_REG;
    return r;
  endfunction

  // Performs this edge's endpoint calls and returns the complete next register state.
  function automatic regs_t xfer_step(input regs_t cur, input logic do_get, input logic do_put,
                                      input logic acc, input logic [SEND_BITS-1:0] din,
                                      input logic [PW-1:0] poll_nxt);
    regs_t nxt;
    msg_t  rx_buf;
    msg_t  tx_buf;
    int    rc;
    int    sz;
    logic  fail;
    nxt  = cur;
    fail = 1'b0;
    case (cur.st)
      ST_REG: begin
        rc = cosim_ep_register(ENDPOINT_ID, ESI_TYPE_ID, RECV_BYTES);
        if (rc == 0) begin
          nxt.reg_flag = 1'b1;
          nxt.st       = ST_ACTIVE;
        end else begin
          nxt.err = 1'b1;
          nxt.st  = ST_ERR;
        end
      end
      ST_ACTIVE: begin
        nxt.poll = poll_nxt;
        if (acc) nxt.out_valid = 1'b0;
        if (do_get) begin
          sz = RECV_BYTES;
          rc = cosim_ep_tryget(ENDPOINT_ID, rx_buf, sz);
          if (rc < 0) begin
            fail = 1'b1;
          end else if (sz != 0) begin
            if (rc > 0 || sz != RECV_BYTES) begin
              if (cur.drop != 16'hFFFF) nxt.drop = cur.drop + 16'd1;
            end else begin
              nxt.out_data  = rx_buf[RECV_BITS-1:0];
              nxt.out_valid = 1'b1;
            end
          end
        end
        if (do_put) begin
          tx_buf                  = '0;
          tx_buf[SEND_BITS-1:0]   = din;
          rc = cosim_ep_tryput(ENDPOINT_ID, tx_buf, SEND_BYTES);
          if (rc < 0) fail = 1'b1;
        end
        if (fail) begin
          nxt.err       = 1'b1;
          nxt.out_valid = 1'b0;
          nxt.st        = ST_ERR;
        end
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  always_comb begin
    active = (regs_q.st == ST_ACTIVE) && !rst;
    accept = regs_q.out_valid && DataOutReady;
    get_en = active && (regs_q.poll == '0) && (!regs_q.out_valid || DataOutReady);
    put_en = active && DataInValid;
    poll_d = (regs_q.poll == '0) ? POLL_RELOAD : regs_q.poll - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= reset_regs(regs_q.reg_flag);
    else     regs_q <= xfer_step(regs_q, get_en, put_en, accept, DataIn, poll_d);
  end

  assign DataOutValid = regs_q.out_valid;
  assign DataOut      = regs_q.out_data;
  assign DataInReady  = active;
  assign Registered   = regs_q.reg_flag;
  assign Error        = regs_q.err;
  assign DropCount    = regs_q.drop;
endmodule

// File: tb/tb_cosim_endpoint_xfer.sv
// Directed bench for cosim_endpoint_xfer: a vector table for the receive path plus
// hand-written sequences for holding, send packing, reset, and error handling.
module tb_cosim_endpoint_xfer;
  import cosim_ep_pkg::*;

  logic        clk = 1'b0;
  logic        rst1, rst2;
  logic        ov1, or1, iv1, ir1, reg1, err1;
  logic [31:0] do1;
  logic [11:0] di1;
  logic [15:0] drop1;
  logic        ov2, or2, iv2, ir2, reg2, err2;
  logic [31:0] do2, di2;
  logic [15:0] drop2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cosim_endpoint_xfer #(.ENDPOINT_ID(1), .ESI_TYPE_ID(64'h1234), .RECV_BITS(32),
                        .SEND_BITS(12), .POLL_INTERVAL(1)) dut1 (
    .clk(clk), .rst(rst1), .DataOutValid(ov1), .DataOutReady(or1), .DataOut(do1),
    .DataInValid(iv1), .DataInReady(ir1), .DataIn(di1), .Registered(reg1),
    .Error(err1), .DropCount(drop1));

  cosim_endpoint_xfer #(.ENDPOINT_ID(1), .POLL_INTERVAL(3)) dut2 (
    .clk(clk), .rst(rst2), .DataOutValid(ov2), .DataOutReady(or2), .DataOut(do2),
    .DataInValid(iv2), .DataInReady(ir2), .DataIn(di2), .Registered(reg2),
    .Error(err2), .DropCount(drop2));

  typedef struct {
    logic [39:0] msg;
    int          len;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic msg_t mk(input logic [39:0] v);
    msg_t m;
    m        = '0;
    m[39:0]  = v;
    return m;
  endfunction

  initial begin
    msg_t got_data;
    int   got_len;
    bit   got;
    int   snap;

    vecs[0] = '{40'h44332211,   4, 1'b1, 32'h44332211, 16'd0};
    vecs[1] = '{40'h2211,       2, 1'b0, 32'h0,        16'd1};
    vecs[2] = '{40'hDEADBEEF,   4, 1'b1, 32'hDEADBEEF, 16'd1};
    vecs[3] = '{40'h5544332211, 5, 1'b0, 32'h0,        16'd2};
    vecs[4] = '{40'h00000000,   4, 1'b1, 32'h00000000, 16'd2};
    vecs[5] = '{40'h332211,     3, 1'b0, 32'h0,        16'd3};

    rst1 = 1'b1; rst2 = 1'b1; or1 = 1'b1; iv1 = 1'b0; di1 = '0;
    or2 = 1'b0; iv2 = 1'b0; di2 = '0; put_fail = 1'b0;
    tick(); tick();
    check("rst_valid", ov1, 0);
    check("rst_inready", ir1, 0);
    check("rst_error", err1, 0);
    check("rst_drop", drop1, 0);
    check("rst_registered", reg1, 0);

    rst1 = 1'b0;
    tick();
    check("registered", reg1, 1);
    check("reg_error", err1, 0);
    check("reg_inready", ir1, 1);
    check("reg_calls", register_calls[1], 1);

    for (int i = 0; i < 6; i++) begin
      host_push(1, mk(vecs[i].msg), vecs[i].len);
      tick();
      check($sformatf("vec%0d_valid", i), ov1, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), do1, vecs[i].exp_data);
      check($sformatf("vec%0d_drop", i), drop1, vecs[i].exp_drop);
      tick();
      check($sformatf("vec%0d_done", i), ov1, 0);
    end

    or1 = 1'b0;
    host_push(1, mk(40'hA1A1A1A1), 4);
    host_push(1, mk(40'hB2B2B2B2), 4);
    host_push(1, mk(40'hC3C3C3C3), 4);
    tick();
    snap = tryget_calls[1];
    for (int k = 0; k < 10; k++) begin
      check($sformatf("hold%0d_valid", k), ov1, 1);
      check($sformatf("hold%0d_data", k), do1, 32'hA1A1A1A1);
      tick();
    end
    check("hold_no_poll", tryget_calls[1], snap);
    check("hold_last_a", do1, 32'hA1A1A1A1);
    or1 = 1'b1;
    tick();
    check("b2b_b_valid", ov1, 1);
    check("b2b_b_data", do1, 32'hB2B2B2B2);
    tick();
    check("b2b_c_valid", ov1, 1);
    check("b2b_c_data", do1, 32'hC3C3C3C3);
    tick();
    check("b2b_end", ov1, 0);

    host_push(1, mk(40'h01020304), 4);
    di1 = 12'hABC; iv1 = 1'b1;
    tick();
    iv1 = 1'b0; di1 = '0;
    check("both_rx_valid", ov1, 1);
    check("both_rx_data", do1, 32'h01020304);
    got = host_pop(1, got_data, got_len);
    check("send_got", got, 1);
    check("send_len", got_len, 2);
    check("send_byte0", got_data[7:0], 8'hBC);
    check("send_byte1", got_data[15:8], 8'h0A);
    check("send_pad", got_data[127:16], 0);
    tick();
    got = host_pop(1, got_data, got_len);
    check("send_once", got, 0);
    check("both_end", ov1, 0);

    or1 = 1'b0;
    host_push(1, mk(40'hCAFEF00D), 4);
    tick();
    check("rstmid_pre", do1, 32'hCAFEF00D);
    snap = register_calls[1];
    rst1 = 1'b1;
    tick();
    check("rstmid_valid", ov1, 0);
    check("rstmid_inready", ir1, 0);
    host_push(1, mk(40'h12345678), 4);
    tick();
    rst1 = 1'b0;
    tick();
    check("rstmid_noreg", register_calls[1], snap);
    check("rstmid_registered", reg1, 1);
    check("rstmid_next_valid", ov1, 1);
    check("rstmid_next_data", do1, 32'h12345678);
    or1 = 1'b1;
    tick();
    check("rstmid_end", ov1, 0);

    put_fail = 1'b1; iv1 = 1'b1;
    tick();
    put_fail = 1'b0; iv1 = 1'b0;
    check("putfail_error", err1, 1);
    check("putfail_inready", ir1, 0);
    host_push(1, mk(40'h0BADCAFE), 4);
    tick(); tick(); tick();
    check("err_no_get", host_pending(1), 1);
    check("err_sticky", err1, 1);
    check("err_valid", ov1, 0);
    rst1 = 1'b1;
    tick();
    check("err_rst_clear", err1, 0);
    rst1 = 1'b0;
    tick();
    check("err_recover_valid", ov1, 1);
    check("err_recover_data", do1, 32'h0BADCAFE);
    tick();

    rst1 = 1'b1;
    tick();
    snap = tryget_calls[1];
    host_push(1, mk(40'h77665544), 4);
    rst2 = 1'b0;
    tick();
    check("dup_error", err2, 1);
    check("dup_inready", ir2, 0);
    check("dup_registered", reg2, 0);
    check("dup_valid", ov2, 0);
    for (int k = 0; k < 5; k++) tick();
    check("dup_no_get", tryget_calls[1], snap);
    check("dup_pending", host_pending(1), 1);
    check("dup_type_kept", host_type_id(1), 64'h1234);
    check("dup_bytes_kept", host_recv_bytes(1), 4);
    rst1 = 1'b0;
    tick();
    check("dup_dut1_valid", ov1, 1);
    check("dup_dut1_data", do1, 32'h77665544);
    check("dup_still_err", err2, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
